spi_regfile_peripheral: RTL and testbench

//  Parametrised SPI (mode 0) slave register file; generalises the fixed 5x8-bit write-only peripheral.

---
 rtl/spi_regfile_peripheral.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile_peripheral
// Brief    : SPI mode-0 slave register file. A frame is one R/W bit, ADDR_W
//            address bits and DATA_W data bits, MSB first, sampled on the
//            rising edge of sclk. All pins are synchronised into clk.
//            Write frames commit when chip select rises. Read frames can
//            return register contents on cipo.
// Options  : SPI_READBACK_EN - when defined, read frames drive cipo/cipo_oe.
//            When undefined, cipo and cipo_oe stay low. Read frames are
//            consumed silently.
// Revision : 1.0 - initial release
// ============================================================================
module spi_regfile_peripheral #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic                       frame_err
);

    localparam int c_FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int c_CNT_W     = $clog2(c_FRAME_LEN + 2);
    localparam int c_AW1       = ADDR_W + 1;

    // Count value just before the last address bit arrives.
    localparam logic [c_CNT_W-1:0] c_CNT_CMD_LAST = c_CNT_W'(ADDR_W);
    // Count once the whole command (rw + addr) has been received.
    localparam logic [c_CNT_W-1:0] c_CNT_CMD_DONE = c_CNT_W'(ADDR_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FRAME    = c_CNT_W'(c_FRAME_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX      = c_CNT_W'(c_FRAME_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [ADDR_W:0]    c_NUM_REGS_A   = c_AW1'(NUM_REGS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CMD  = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    generate
        if (NUM_REGS > (1 << ADDR_W)) begin : g_chk_num_regs
            $error("spi_regfile_peripheral: NUM_REGS exceeds 2**ADDR_W");
        end
        if (SYNC_STAGES < 2) begin : g_chk_sync_stages
            $error("spi_regfile_peripheral: SYNC_STAGES must be >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pin synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_vld;
    logic                   r_sclk_prev;
    logic                   r_ncs_prev;
    logic                   r_armed;

    logic w_sclk_s;
    logic w_ncs_s;
    logic w_copi_s;
    logic w_sclk_rise;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_ncs_fall_ok;

    // Shift the async pins through the synchroniser chains.
    // r_vld marks when the chains hold real pin samples instead of reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_copi_sync <= '0;
            r_vld       <= '0;
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_ncs_prev  <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev;

    // Arm frame detection only after a genuine high on ncs.
    // This ignores a frame already in progress when reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (r_vld[SYNC_STAGES-1] && w_ncs_s) begin
            r_armed <= 1'b1;
        end
    end

    assign w_ncs_fall_ok = w_ncs_fall & r_armed;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_cmd;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic               r_overrun;

    logic [ADDR_W:0]    w_cmd_next;
    logic [DATA_W-1:0]  w_data_next;
    logic               w_bit_en;
    logic               w_addr_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A rising ncs returns to IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        if (w_ncs_rise) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (w_ncs_fall_ok) w_state_next = c_ST_CMD;
                c_ST_CMD:  if (w_addr_done)   w_state_next = c_ST_DATA;
                c_ST_DATA: w_state_next = c_ST_DATA;
                default:   w_state_next = c_ST_IDLE;
            endcase
        end
    end

    // A bit is taken only inside a frame. An ncs rise in the same cycle
    // as an sclk rise discards that bit.
    assign w_bit_en    = w_sclk_rise & ~w_ncs_rise & (r_state != c_ST_IDLE);
    assign w_addr_done = w_bit_en & (r_state == c_ST_CMD) & (r_cnt == c_CNT_CMD_LAST);
    assign w_cmd_next  = {r_cmd, w_copi_s};
    assign w_data_next = (r_data << 1) | DATA_W'(w_copi_s);

    // Bit counter and shift registers for the command and data fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_rw      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && w_ncs_fall_ok) begin
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else if (w_bit_en) begin
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (r_state == c_ST_CMD) begin
                r_cmd <= w_cmd_next[ADDR_W-1:0];
                if (r_cnt == c_CNT_CMD_LAST) begin
                    r_rw   <= w_cmd_next[ADDR_W];
                    r_addr <= w_cmd_next[ADDR_W-1:0];
                end
            end else if (r_cnt < c_CNT_FRAME) begin
                r_data <= w_data_next;
            end else begin
                r_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Commit, error reporting and register storage
    // ------------------------------------------------------------------
    logic                w_frame_end;
    logic                w_len_ok;
    logic                w_addr_ok;
    logic                w_commit;
    logic [NUM_REGS-1:0] w_hit;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_wr_strobe;
    logic                r_frame_err;

    assign w_frame_end = w_ncs_rise & (r_state != c_ST_IDLE);
    assign w_len_ok    = (r_cnt == c_CNT_FRAME) & ~r_overrun;
    assign w_addr_ok   = ({1'b0, r_addr} < c_NUM_REGS_A);
    assign w_commit    = w_frame_end & w_len_ok & r_rw & w_addr_ok;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(gi);
            assign w_hit[gi] = w_commit & (r_addr == c_IDX);
            assign regs_out[gi*DATA_W +: DATA_W] = r_regs[gi];
        end
    endgenerate

    // Register write and strobe on the frame-end cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_strobe <= '0;
        end else begin
            r_wr_strobe <= w_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_hit[i]) begin
                    r_regs[i] <= r_data;
                end
            end
        end
    end

    // Pulse frame_err for any frame ending with the wrong bit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_end & ~w_len_ok;
        end
    end

    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

    // ------------------------------------------------------------------
    // Readback path
    // ------------------------------------------------------------------
`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_sclk_fall;

    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;

    // Select the register named by the address field. Out of range reads as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_next[ADDR_W-1:0] == ADDR_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Load on address completion of a read.
    // Advance on sclk falls once the first data bit has gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= '0;
        end else if (w_addr_done && !w_cmd_next[ADDR_W]) begin
            r_tx <= w_rd_data;
        end else if (w_sclk_fall && !w_ncs_rise && (r_state == c_ST_DATA) &&
                     (r_cnt > c_CNT_CMD_DONE)) begin
            r_tx <= r_tx << 1;
        end
    end

    assign cipo_oe = (r_state == c_ST_DATA) & ~r_rw;
    assign cipo    = cipo_oe & r_tx[DATA_W-1];
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_regfile_peripheral
// Brief    : Self-checking bench for spi_regfile_peripheral.
//            Directed frame table, hand-written corner sequences, and
//            random frames checked against a register-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_regfile_peripheral;

    localparam int ADDR_W      = 7;
    localparam int DATA_W      = 8;
    localparam int NUM_REGS    = 5;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 6;   // clk periods per sclk phase

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic sclk = 1'b0;
    logic ncs  = 1'b1;
    logic copi = 1'b0;
    logic                       cipo;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic [NUM_REGS-1:0]        wr_strobe;
    logic                       frame_err;

    spi_regfile_peripheral #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .ncs      (ncs),
        .copi     (copi),
        .cipo     (cipo),
        .cipo_oe  (cipo_oe),
        .regs_out (regs_out),
        .wr_strobe(wr_strobe),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Pulse monitors
    int strobe_cnt [NUM_REGS];
    int err_pulses = 0;
    int strobe_order[$];

    always @(negedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_strobe[i] === 1'b1) begin
                strobe_cnt[i]++;
                strobe_order.push_back(i);
            end
        end
        if (frame_err === 1'b1) err_pulses++;
    end

    // Reference model: the register array as seen by the SPI host
    logic [DATA_W-1:0] model_regs [NUM_REGS];

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model_regs[i];
        return f;
    endfunction

    // A frame counts as complete only with exactly 16 bits.
    // Complete writes to a valid address update the array.
    function automatic void model_frame(input logic [31:0] bits, input int nbits,
                                        output int exp_err, output int exp_idx,
                                        output logic [7:0] exp_rd);
        int addr;
        exp_err = (nbits != 16) ? 1 : 0;
        exp_idx = -1;
        exp_rd  = 8'h00;
        if (nbits == 16) begin
            addr = int'(bits[14:8]);
            if (!bits[15]) begin
                exp_rd = (addr < NUM_REGS) ? model_regs[addr] : 8'h00;
            end else if (addr < NUM_REGS) begin
                model_regs[addr] = bits[7:0];
                exp_idx = addr;
            end
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        sclk = 1'b0;
        ncs  = 1'b0;
        tick(HALF);
    endtask

    task automatic spi_bit(input logic b, output logic smp_cipo, output logic smp_oe);
        copi = b;
        tick(HALF);
        smp_cipo = cipo;
        smp_oe   = cipo_oe;
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_stop(input int gap);
        tick(HALF);
        ncs = 1'b1;
        tick(gap);
    endtask

    task automatic run_frame(input logic [31:0] bits, input int nbits, input int gap,
                             output logic [31:0] rx, output logic [31:0] oe);
        logic c, o;
        rx = '0;
        oe = '0;
        spi_start();
        for (int k = 0; k < nbits; k++) begin
            spi_bit(bits[nbits-1-k], c, o);
            rx = {rx[30:0], c};
            oe = {oe[30:0], o};
        end
        spi_stop(gap);
    endtask

    // One frame checked against the model.
    // Returns the observed error pulses and strobe mask.
    task automatic do_frame(input string tag, input logic [31:0] bits, input int nbits,
                            input int gap, output int got_err,
                            output logic [NUM_REGS-1:0] got_mask);
        int s0 [NUM_REGS];
        int e0, tot, exp_err, exp_idx;
        logic [7:0] exp_rd;
        logic is_read;
        logic [31:0] rx, oe;
        logic [NUM_REGS-1:0] exp_mask;
        for (int i = 0; i < NUM_REGS; i++) s0[i] = strobe_cnt[i];
        e0 = err_pulses;
        is_read = (nbits == 16) && !bits[15];
        model_frame(bits, nbits, exp_err, exp_idx, exp_rd);
        run_frame(bits, nbits, gap, rx, oe);
        got_err  = err_pulses - e0;
        got_mask = '0;
        tot      = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (strobe_cnt[i] != s0[i]) got_mask[i] = 1'b1;
            tot += strobe_cnt[i] - s0[i];
        end
        exp_mask = '0;
        if (exp_idx >= 0) exp_mask[exp_idx] = 1'b1;
        check({tag, " frame_err"}, 64'(got_err), 64'(exp_err));
        check({tag, " strobe_mask"}, 64'(got_mask), 64'(exp_mask));
        check({tag, " strobe_pulses"}, 64'(tot), (exp_idx >= 0) ? 64'd1 : 64'd0);
        check({tag, " regs_out"}, 64'(regs_out), 64'(model_flat()));
        if (is_read) begin
`ifdef SPI_READBACK_EN
            check({tag, " cipo_data"}, 64'(rx[15:0]), {56'd0, exp_rd});
            check({tag, " cipo_oe"}, 64'(oe[15:0]), 64'h00FF);
`else
            check({tag, " cipo_data"}, 64'(rx[15:0]), 64'd0);
            check({tag, " cipo_oe"}, 64'(oe[15:0]), 64'd0);
`endif
        end
        check({tag, " idle_oe"}, 64'(cipo_oe), 64'd0);
    endtask

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          gap;
        int          exp_err;
        int          exp_idx;
        int          chk_reg;
        logic [7:0]  chk_val;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    initial begin
        #5ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int got_err, exp_err, exp_idx, n, r;
        logic [NUM_REGS-1:0] got_mask, exp_mask;
        logic [7:0] exp_rd, data;
        logic [6:0] addr;
        logic rw, c, o;
        logic [15:0] w16;
        logic [31:0] bits;
        int e0, s0;

        tbl[0] = '{32'h80A5,  16, 8, 0,  0, 0, 8'hA5};
        tbl[1] = '{32'h843C,  16, 8, 0,  4, 4, 8'h3C};
        tbl[2] = '{32'h0400,  16, 8, 0, -1, 4, 8'h3C};
        tbl[3] = '{32'h40BF,  15, 8, 1, -1, 1, 8'h00};
        tbl[4] = '{32'h102FE, 17, 8, 1, -1, 1, 8'h00};
        tbl[5] = '{32'h90FF,  16, 8, 0, -1, 0, 8'hA5};
        tbl[6] = '{32'h1000,  16, 8, 0, -1, 0, 8'hA5};
        tbl[7] = '{32'h0000,   0, 8, 1, -1, 0, 8'hA5};
        tbl[8] = '{32'h8111,  16, 4, 0,  1, 1, 8'h11};
        tbl[9] = '{32'h8222,  16, 8, 0,  2, 2, 8'h22};

        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;

        // Reset state
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset regs_out", 64'(regs_out), 64'd0);
        check("reset wr_strobe", 64'(wr_strobe), 64'd0);
        check("reset frame_err", 64'(frame_err), 64'd0);
        check("reset cipo", 64'(cipo), 64'd0);
        check("reset cipo_oe", 64'(cipo_oe), 64'd0);
        tick(4);

        // Directed frame table
        for (int v = 0; v < NVEC; v++) begin
            do_frame($sformatf("vec%0d", v), tbl[v].bits, tbl[v].nbits, tbl[v].gap,
                     got_err, got_mask);
            exp_mask = '0;
            if (tbl[v].exp_idx >= 0) exp_mask[tbl[v].exp_idx] = 1'b1;
            check($sformatf("vec%0d tbl_err", v), 64'(got_err), 64'(tbl[v].exp_err));
            check($sformatf("vec%0d tbl_mask", v), 64'(got_mask), 64'(exp_mask));
            check($sformatf("vec%0d tbl_reg", v),
                  64'(regs_out[tbl[v].chk_reg*DATA_W +: DATA_W]), 64'(tbl[v].chk_val));
        end
        n = strobe_order.size();
        check("b2b order first", (n >= 2) ? 64'(strobe_order[n-2]) : 64'hDEAD, 64'd1);
        check("b2b order second", (n >= 1) ? 64'(strobe_order[n-1]) : 64'hDEAD, 64'd2);

        // rst for one clk after 10 bits of a write, then finish the frame
        e0 = err_pulses;
        s0 = strobe_order.size();
        w16 = 16'h8255;
        spi_start();
        for (int k = 0; k < 10; k++) spi_bit(w16[15-k], c, o);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        for (int k = 10; k < 16; k++) spi_bit(w16[15-k], c, o);
        spi_stop(8);
        check("rst_mid regs_out", 64'(regs_out), 64'd0);
        check("rst_mid strobes", 64'(strobe_order.size() - s0), 64'd0);
        check("rst_mid frame_err", 64'(err_pulses - e0), 64'd0);
        do_frame("after_rst", 32'h8255, 16, 8, got_err, got_mask);
        check("after_rst reg2", 64'(regs_out[2*DATA_W +: DATA_W]), 64'h55);

        // 17th sclk rise coincides with the ncs rise: that bit is discarded
        e0 = err_pulses;
        s0 = strobe_order.size();
        model_frame(32'h839C, 16, exp_err, exp_idx, exp_rd);
        w16 = 16'h839C;
        spi_start();
        for (int k = 0; k < 16; k++) spi_bit(w16[15-k], c, o);
        copi = 1'b1;
        tick(HALF);
        sclk = 1'b1;
        ncs  = 1'b1;
        tick(HALF);
        sclk = 1'b0;
        // sclk activity while deselected must be ignored
        for (int k = 0; k < 3; k++) begin
            tick(HALF);
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
        tick(8);
        check("coincide frame_err", 64'(err_pulses - e0), 64'd0);
        check("coincide strobes", 64'(strobe_order.size() - s0), 64'd1);
        check("coincide reg3", 64'(regs_out[3*DATA_W +: DATA_W]), 64'h9C);
        check("coincide regs_out", 64'(regs_out), 64'(model_flat()));

        // Random frames against the model
        for (int t = 0; t < 40; t++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                               : 7'($urandom_range(0, NUM_REGS));
            data = 8'($urandom);
            w16  = {rw, addr, data};
            r    = $urandom_range(0, 9);
            if (r == 0)      n = 15;
            else if (r == 1) n = 17;
            else if (r == 2) n = $urandom_range(0, 14);
            else             n = 16;
            if (n <= 16) bits = 32'(w16) >> (16 - n);
            else         bits = {15'd0, w16, 1'($urandom_range(0, 1))};
            do_frame($sformatf("rnd%0d", t), bits, n, 6, got_err, got_mask);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
